// File: rtl/pc_unit_if.sv
// pc_unit_if
// Bundles the stall, decode, execute and PC/flag/halt signals exchanged with
// the fetch-stage PC unit.
//   slave  : the PC unit. It reads stall/decode/execute and drives pc,
//            pc_plus_two, redirect, flags and halted.
//   master : the surrounding pipeline. It drives the inputs and reads the
//            results.
// Parameter ADDR_WIDTH must match the ADDR_WIDTH of the attached pc_unit.
interface pc_unit_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  stall;
  logic                  dec_valid;
  logic [15:0]           dec_instr;
  logic [ADDR_WIDTH-1:0] dec_pc_plus_two;
  logic [ADDR_WIDTH-1:0] dec_reg_val;
  logic                  ex_valid;
  logic [3:0]            ex_opcode;
  logic [2:0]            ex_flags;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus_two;
  logic                  redirect;
  logic [2:0]            flags;
  logic                  halted;

  modport master (
    output stall, dec_valid, dec_instr, dec_pc_plus_two, dec_reg_val,
           ex_valid, ex_opcode, ex_flags,
    input  pc, pc_plus_two, redirect, flags, halted
  );

  modport slave (
    input  stall, dec_valid, dec_instr, dec_pc_plus_two, dec_reg_val,
           ex_valid, ex_opcode, ex_flags,
    output pc, pc_plus_two, redirect, flags, halted
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit
// Fetch-stage PC unit. It holds the fetch PC and the {N,Z,V} flag register,
// and it resolves B/BR in decode with a one-cycle redirect. It also runs the
// halt sequence RUN -> DRAIN -> HALTED.
// Ports:
//   clk : system clock. All state changes on the rising edge.
//   rst : synchronous, active-high reset. It overrides every other event.
//   bus : pc_unit_if.slave
//         inputs : stall, dec_valid, dec_instr, dec_pc_plus_two, dec_reg_val,
//                  ex_valid, ex_opcode, ex_flags
//         outputs: pc, pc_plus_two, redirect, flags, halted
// Parameters: ADDR_WIDTH, RESET_VECTOR, DRAIN_CYCLES (0 allowed).
// Optional macro PC_UNIT_FLAG_FWD_EN: when defined, the branch condition
// reads flags forwarded per bit from execute. When undefined, the branch
// reads only the registered flags, so the hazard unit must stall a branch
// while a flag-setting op is in execute.
module pc_unit #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    DRAIN_CYCLES = 3
) (
  input logic      clk,
  input logic      rst,
  pc_unit_if.slave bus
);

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      drain_cnt, drain_cnt_next;
  logic [ADDR_WIDTH-1:0] pc_q, pc_next, pc_inc;
  logic [ADDR_WIDTH-1:0] offset, branch_target;
  logic [2:0]            flags_q, flags_next, cond_flags;
  logic [3:0]            opcode;
  logic [2:0]            cond;
  logic                  load_nv, load_z;
  logic                  cond_met, act, is_branch, is_hlt;
  logic                  take_branch, take_hlt;

  assign opcode = bus.dec_instr[15:12];
  assign cond   = bus.dec_instr[11:9];
  assign pc_inc = pc_q + ADDR_WIDTH'(2);

  // The 9-bit word offset is sign-extended and scaled to bytes. The cast
  // trims it to the address width, so the target wraps modulo 2^ADDR_WIDTH.
  assign offset        = ADDR_WIDTH'({{ADDR_WIDTH{bus.dec_instr[8]}}, bus.dec_instr[8:0], 1'b0});
  assign branch_target = (opcode == OP_B) ? (bus.dec_pc_plus_two + offset) : bus.dec_reg_val;

  // Select which execute ops write which flag bits. N/V come only from
  // ops 0/1. Z also comes from the logical/shift group.
  always_comb begin
    load_nv = 1'b0;
    load_z  = 1'b0;
    if (bus.ex_valid) begin
      case (bus.ex_opcode)
        4'h0, 4'h1:             begin load_nv = 1'b1; load_z = 1'b1; end
        4'h3, 4'h4, 4'h5, 4'h6: load_z = 1'b1;
        default:                ;
      endcase
    end
  end

  // Compute the next flag register. Updates continue in every FSM state.
  always_comb begin
    flags_next = flags_q;
    if (load_nv) begin
      flags_next[2] = bus.ex_flags[2];
      flags_next[0] = bus.ex_flags[0];
    end
    if (load_z) begin
      flags_next[1] = bus.ex_flags[1];
    end
  end

`ifdef PC_UNIT_FLAG_FWD_EN
  // Forward per bit: each bit comes from execute only if that op writes it.
  assign cond_flags = flags_next;
`else
  assign cond_flags = flags_q;
`endif

  // Evaluate the condition code against {N,Z,V}.
  always_comb begin
    cond_met = 1'b0;
    case (cond)
      3'b000: cond_met = ~cond_flags[1];
      3'b001: cond_met = cond_flags[1];
      3'b010: cond_met = ~cond_flags[1] & ~cond_flags[2];
      3'b011: cond_met = cond_flags[2];
      3'b100: cond_met = cond_flags[1] | ~cond_flags[2];
      3'b101: cond_met = cond_flags[2] | cond_flags[1];
      3'b110: cond_met = cond_flags[0];
      3'b111: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  assign act         = bus.dec_valid & ~bus.stall & (state == ST_RUN);
  assign is_branch   = (opcode == OP_B) | (opcode == OP_BR);
  assign is_hlt      = (opcode == OP_HLT);
  assign take_branch = act & is_branch & cond_met;
  assign take_hlt    = act & is_hlt;

  // Redirect is combinational from decode. Reset masks it so it reads 0
  // while rst is held.
  assign bus.redirect    = ~rst & (take_branch | take_hlt);
  assign bus.pc          = pc_q;
  assign bus.pc_plus_two = pc_inc;
  assign bus.flags       = flags_q;
  assign bus.halted      = (state == ST_HALTED);

  // Compute the next state, drain counter and PC. HLT parks the PC on the
  // HLT instruction itself. After that, DRAIN and HALTED freeze the PC.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    pc_next        = pc_q;
    case (state)
      ST_RUN: begin
        if (take_branch) begin
          pc_next = branch_target;
        end else if (take_hlt) begin
          pc_next = bus.dec_pc_plus_two - ADDR_WIDTH'(2);
          if (DRAIN_CYCLES > 0) begin
            state_next     = ST_DRAIN;
            drain_cnt_next = CNT_W'(DRAIN_CYCLES);
          end else begin
            state_next = ST_HALTED;
          end
        end else if (!bus.stall) begin
          pc_next = pc_inc;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt <= CNT_W'(1)) begin
          state_next     = ST_HALTED;
          drain_cnt_next = '0;
        end else begin
          drain_cnt_next = drain_cnt - CNT_W'(1);
        end
      end
      ST_HALTED: ;
      default: state_next = ST_RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      pc_q      <= RESET_VECTOR;
      flags_q   <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_cnt_next;
      pc_q      <= pc_next;
      flags_q   <= flags_next;
    end
  end

endmodule
